// File: rtl/mem_bus_master.sv
// mem_bus_master: arbitrates an instruction and a data port onto one
// word-addressed memory bus with registered strobes and lane steering.
module mem_bus_master #(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      GAP,
      ERR
   } state_t;

   state_t      state, state_nxt;
   logic        last_d, last_d_nxt;
   logic        sel_d, sel_d_nxt;
   logic [1:0]  lo_q, lo_nxt;
   logic [1:0]  size_q, size_nxt;
   logic        sgn_q, sgn_nxt;
   logic        read_nxt, write_nxt;
   logic [31:0] address_nxt;
   logic [3:0]  be_nxt;
   logic [31:0] writedata_nxt;
   logic        i_ack_nxt, d_ack_nxt, d_err_nxt;
   logic [31:0] i_rdata_nxt, d_rdata_nxt;

   logic        gnt_d, gnt_i;
   logic        misalign;
   logic [3:0]  d_be;
   logic [31:0] d_wd;
   logic [31:0] lane;
   logic [31:0] ld_ext;
   logic        unused_addr;

   // fetches are word-granular, the low address bits carry no meaning
   assign unused_addr = ^i_addr[1:0];

   assign gnt_d = d_req && (!i_req || !ROUND_ROBIN || !last_d);
   assign gnt_i = i_req && !gnt_d;

   always_comb begin
      d_be     = 4'b1111;
      d_wd     = d_wdata;
      misalign = |d_addr[1:0];
      unique case (1'b1)
         d_size == 2'b00: begin
            d_be     = 4'b0001 << d_addr[1:0];
            d_wd     = {4{d_wdata[7:0]}};
            misalign = 1'b0;
         end
         d_size == 2'b01: begin
            d_be     = d_addr[1] ? 4'b1100 : 4'b0011;
            d_wd     = {2{d_wdata[15:0]}};
            misalign = d_addr[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      lane   = readdata >> {lo_q, 3'b000};
      ld_ext = lane;
      unique case (1'b1)
         size_q == 2'b00:
            ld_ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
         size_q == 2'b01:
            ld_ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      last_d_nxt    = last_d;
      sel_d_nxt     = sel_d;
      lo_nxt        = lo_q;
      size_nxt      = size_q;
      sgn_nxt       = sgn_q;
      read_nxt      = read;
      write_nxt     = write;
      address_nxt   = address;
      be_nxt        = byteenable;
      writedata_nxt = writedata;
      i_ack_nxt     = 1'b0;
      d_ack_nxt     = 1'b0;
      d_err_nxt     = 1'b0;
      i_rdata_nxt   = i_rdata;
      d_rdata_nxt   = d_rdata;
      unique case (state)
         IDLE: begin
            if (gnt_d) begin
               last_d_nxt = 1'b1;
               sel_d_nxt  = 1'b1;
               lo_nxt     = d_addr[1:0];
               size_nxt   = d_size;
               sgn_nxt    = d_signed;
               if (misalign) begin
                  state_nxt = ERR;
                  d_ack_nxt = 1'b1;
                  d_err_nxt = 1'b1;
               end else begin
                  state_nxt     = ACCESS;
                  read_nxt      = !d_write;
                  write_nxt     = d_write;
                  address_nxt   = {d_addr[31:2], 2'b00};
                  be_nxt        = d_be;
                  writedata_nxt = d_wd;
               end
            end else if (gnt_i) begin
               last_d_nxt    = 1'b0;
               sel_d_nxt     = 1'b0;
               state_nxt     = ACCESS;
               read_nxt      = 1'b1;
               write_nxt     = 1'b0;
               address_nxt   = {i_addr[31:2], 2'b00};
               be_nxt        = 4'b1111;
               writedata_nxt = 32'h0;
            end
         end
         ACCESS: begin
            if (!waitrequest) begin
               state_nxt = GAP;
               read_nxt  = 1'b0;
               write_nxt = 1'b0;
               if (sel_d) begin
                  d_ack_nxt = 1'b1;
                  if (read) d_rdata_nxt = ld_ext;
               end else begin
                  i_ack_nxt   = 1'b1;
                  i_rdata_nxt = readdata;
               end
            end
         end
         GAP:     state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_d     <= 1'b0;
         sel_d      <= 1'b0;
         lo_q       <= 2'b00;
         size_q     <= 2'b00;
         sgn_q      <= 1'b0;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= 32'h0;
         byteenable <= 4'h0;
         writedata  <= 32'h0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         d_err      <= 1'b0;
         i_rdata    <= 32'h0;
         d_rdata    <= 32'h0;
      end else begin
         state      <= state_nxt;
         last_d     <= last_d_nxt;
         sel_d      <= sel_d_nxt;
         lo_q       <= lo_nxt;
         size_q     <= size_nxt;
         sgn_q      <= sgn_nxt;
         read       <= read_nxt;
         write      <= write_nxt;
         address    <= address_nxt;
         byteenable <= be_nxt;
         writedata  <= writedata_nxt;
         i_ack      <= i_ack_nxt;
         d_ack      <= d_ack_nxt;
         d_err      <= d_err_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: table, directed and random checks of
// mem_bus_master against a behavioural bus model.
module tb_mem_bus_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [1:0]  d_size = 2'b00;
   logic        d_signed = 1'b0;
   logic [31:0] d_wdata = 32'h0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] address;
   logic        read, write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = 32'h0;

   logic        x_i_ack, x_d_ack, x_d_err;
   logic [31:0] x_i_rdata, x_d_rdata, x_address, x_writedata;
   logic        x_read, x_write;
   logic [3:0]  x_byteenable;

   always #5 clk = ~clk;

   mem_bus_master #(.ROUND_ROBIN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_size(d_size),
      .d_signed(d_signed), .d_wdata(d_wdata), .d_ack(d_ack),
      .d_rdata(d_rdata), .d_err(d_err),
      .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata),
      .waitrequest(waitrequest), .readdata(readdata)
   );

   // data port always wins: with both requests held, no fetch ever completes
   mem_bus_master #(.ROUND_ROBIN(1'b0)) dut_fix (
      .clk(clk), .reset(reset),
      .i_req(1'b1), .i_addr(32'h100), .i_ack(x_i_ack), .i_rdata(x_i_rdata),
      .d_req(1'b1), .d_write(1'b0), .d_addr(32'h10), .d_size(2'b10),
      .d_signed(1'b0), .d_wdata(32'h0), .d_ack(x_d_ack),
      .d_rdata(x_d_rdata), .d_err(x_d_err),
      .address(x_address), .read(x_read), .write(x_write),
      .byteenable(x_byteenable), .writedata(x_writedata),
      .waitrequest(1'b0), .readdata(32'h0)
   );

   int checks = 0;
   int errors = 0;
   int fix_i = 0;
   int fix_d = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (x_i_ack) fix_i <= fix_i + 1;
         if (x_d_ack) fix_d <= fix_d + 1;
      end
   end

   typedef struct {
      bit          is_d;
      bit          wr;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          sgn;
      logic [31:0] wd;
      logic [31:0] rd;
      int          nwait;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] erd;
      bit          err;
      int          lat;
   } vec_t;

   vec_t        tbl[15];
   logic [31:0] last_ld = 32'h0;
   bit          ld_known = 1'b1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit is_d, input bit wr,
      input logic [31:0] addr, input logic [1:0] size, input bit sgn,
      input logic [31:0] wd, input logic [31:0] rd, input int nw,
      input logic [3:0] be, input logic [31:0] ewd,
      input logic [31:0] erd, input bit err, input int lat);
      vec_t v;
      v.is_d = is_d; v.wr = wr; v.addr = addr; v.size = size;
      v.sgn = sgn; v.wd = wd; v.rd = rd; v.nwait = nw;
      v.be = be; v.ewd = ewd; v.erd = erd; v.err = err; v.lat = lat;
      return v;
   endfunction

   // reference: bytes touched, lane offset and extension by arithmetic
   function automatic vec_t model(input vec_t v, input logic [31:0] prev);
      vec_t        r;
      int          nb, off;
      logic [31:0] mask, val;
      r = v;
      if (!v.is_d) begin
         r.wr = 1'b0; r.be = 4'hF; r.ewd = 32'h0; r.erd = v.rd;
         r.err = 1'b0; r.lat = 2 + v.nwait;
         return r;
      end
      nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
      off = int'(v.addr % 32'd4);
      r.err = (off % nb) != 0;
      r.be  = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++)
         r.ewd[8*i +: 8] = v.wd[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*nb)) - 32'd1;
      val  = (v.rd >> (8*off)) & mask;
      if (v.sgn && nb < 4 && val[8*nb-1]) val = val | ~mask;
      r.erd = r.err ? prev : val;
      r.lat = r.err ? 1 : 2 + v.nwait;
      return r;
   endfunction

   task automatic xfer(input vec_t v, input bit chk_rd, input string name);
      int          lat = -1;
      int          strobes = 0;
      int          bad = 0;
      logic [31:0] got_rd = 32'h0;
      logic        got_err = 1'b0;
      @(posedge clk); #1;
      readdata = v.rd;
      waitrequest = (v.nwait > 0);
      if (v.is_d) begin
         d_req = 1'b1; d_write = v.wr; d_addr = v.addr;
         d_size = v.size; d_signed = v.sgn; d_wdata = v.wd;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      for (int k = 0; k < v.nwait + 8 && lat < 0; k++) begin
         @(negedge clk);
         if (read && write) bad++;
         if (read || write) begin
            strobes++;
            if (k == 0) bad++;
            if (address !== {v.addr[31:2], 2'b00}) bad++;
            if (byteenable !== v.be) bad++;
            if (write !== (v.is_d && v.wr)) bad++;
            if (v.is_d && v.wr && writedata !== v.ewd) bad++;
            waitrequest = (strobes <= v.nwait);
         end
         if ((v.is_d ? i_ack : d_ack) === 1'b1) bad++;
         if ((v.is_d ? d_ack : i_ack) === 1'b1) begin
            lat = k;
            got_rd = v.is_d ? d_rdata : i_rdata;
            got_err = d_err;
            d_req = 1'b0;
            i_req = 1'b0;
         end
      end
      d_req = 1'b0;
      i_req = 1'b0;
      waitrequest = 1'b0;
      chk({name, " latency"}, lat, v.lat);
      chk({name, " strobes"}, strobes, v.err ? 0 : v.nwait + 1);
      chk({name, " bus fields"}, bad, 0);
      if (v.is_d) chk({name, " d_err"}, 32'(got_err), 32'(v.err));
      if (chk_rd) chk({name, " rdata"}, got_rd, v.erd);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      bit c;
      c = !v.is_d || (!v.wr && !v.err) || (v.err && ld_known);
      xfer(v, c, name);
      if (v.is_d && !v.err) begin
         ld_known = !v.wr;
         if (!v.wr) last_ld = v.erd;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          acks, n, b2b;
      logic        prev;
      logic [3:0]  order;
      vec_t        v;

      tbl[0]  = mk(1,0,32'h10, 2'd2,0,32'h0,32'hDEADBEEF,0,
                   4'hF,32'h0,32'hDEADBEEF,0,2);
      tbl[1]  = mk(1,0,32'h13, 2'd0,1,32'h0,32'h80000000,0,
                   4'h8,32'h0,32'hFFFFFF80,0,2);
      tbl[2]  = mk(1,0,32'h13, 2'd0,0,32'h0,32'h80000000,0,
                   4'h8,32'h0,32'h00000080,0,2);
      tbl[3]  = mk(1,0,32'h101,2'd2,0,32'h0,32'h55555555,0,
                   4'hF,32'h0,32'h00000080,1,1);
      tbl[4]  = mk(1,1,32'h22, 2'd1,0,32'h1234ABCD,32'h0,5,
                   4'hC,32'hABCDABCD,32'h0,0,7);
      tbl[5]  = mk(1,0,32'h12, 2'd1,1,32'h0,32'h80017FFF,0,
                   4'hC,32'h0,32'hFFFF8001,0,2);
      tbl[6]  = mk(1,0,32'h10, 2'd1,0,32'h0,32'h80018002,1,
                   4'h3,32'h0,32'h00008002,0,3);
      tbl[7]  = mk(1,1,32'h05, 2'd0,0,32'h000000A5,32'h0,1,
                   4'h2,32'hA5A5A5A5,32'h0,0,3);
      tbl[8]  = mk(1,1,32'h08, 2'd2,0,32'hCAFEF00D,32'h0,2,
                   4'hF,32'hCAFEF00D,32'h0,0,4);
      tbl[9]  = mk(1,0,32'h11, 2'd0,1,32'h0,32'h00007F00,0,
                   4'h2,32'h0,32'h0000007F,0,2);
      tbl[10] = mk(1,0,32'h0C, 2'd3,0,32'h0,32'h12345678,0,
                   4'hF,32'h0,32'h12345678,0,2);
      tbl[11] = mk(1,1,32'h03, 2'd1,0,32'h0000FFFF,32'h0,0,
                   4'h0,32'h0,32'h12345678,1,1);
      tbl[12] = mk(1,0,32'h0E, 2'd3,1,32'h0,32'h0,0,
                   4'h0,32'h0,32'h12345678,1,1);
      tbl[13] = mk(0,0,32'h104,2'd0,0,32'h0,32'h00000013,0,
                   4'hF,32'h0,32'h00000013,0,2);
      tbl[14] = mk(0,0,32'h203,2'd0,0,32'h0,32'hA0B0C0D0,3,
                   4'hF,32'h0,32'hA0B0C0D0,0,5);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset read", 32'(read), 0);
      chk("reset write", 32'(write), 0);
      chk("reset i_ack", 32'(i_ack), 0);
      chk("reset d_ack", 32'(d_ack), 0);
      chk("reset d_err", 32'(d_err), 0);
      chk("reset address", address, 0);
      chk("reset byteenable", 32'(byteenable), 0);
      chk("reset writedata", writedata, 0);
      chk("reset i_rdata", i_rdata, 0);
      chk("reset d_rdata", d_rdata, 0);
      reset = 1'b0;

      for (int t = 0; t < 15; t++)
         run_vec(tbl[t], $sformatf("vec%0d", t));

      // reset in the middle of a stalled load
      @(posedge clk); #1;
      readdata = 32'hDEADBEEF;
      waitrequest = 1'b1;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h10;
      d_size = 2'd2; d_signed = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid-access read", 32'(read), 1);
      reset = 1'b1;
      #1;
      chk("async reset read", 32'(read), 0);
      chk("async reset d_ack", 32'(d_ack), 0);
      chk("async reset address", address, 0);
      chk("async reset d_rdata", d_rdata, 0);
      @(posedge clk); #1;
      d_req = 1'b0;
      waitrequest = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (d_ack || i_ack) acks++;
      end
      chk("no ack after reset", acks, 0);
      last_ld = 32'h0;
      ld_known = 1'b1;
      run_vec(tbl[0], "post-reset lw");

      // both ports held: alternation starts with data after reset
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      readdata = 32'h11112222;
      waitrequest = 1'b0;
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h80;
      d_size = 2'd2; d_signed = 1'b0;
      order = 4'h0; n = 0; b2b = 0; prev = 1'b0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         @(negedge clk);
         if (read && prev) b2b++;
         prev = read;
         if (d_ack || i_ack) begin
            order = {order[2:0], d_ack};
            n++;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
      chk("rr grant count", n, 4);
      chk("rr order DIDI", 32'(order), 32'(4'b1010));
      chk("rr strobe gap", b2b, 0);
      last_ld = 32'h11112222;
      ld_known = 1'b1;

      for (int r = 0; r < 60; r++) begin
         v.is_d  = ($urandom_range(0, 3) != 0);
         v.wr    = 1'($urandom_range(0, 1));
         v.addr  = $urandom;
         v.size  = 2'($urandom_range(0, 3));
         v.sgn   = 1'($urandom_range(0, 1));
         v.wd    = $urandom;
         v.rd    = $urandom;
         v.nwait = int'($urandom_range(0, 3));
         v = model(v, last_ld);
         run_vec(v, $sformatf("rnd%0d", r));
      end

      chk("fixed priority fetches", fix_i, 0);
      chk("fixed priority data busy", 32'(fix_d > 10), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter ROUND_ROBIN, default 1: 1 = alternate grants when both ports request; 0 = data port always wins.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  instruction fetch request, held high until i_ack.
REQ-005 i_addr  in  32  fetch byte address.
REQ-006 i_ack  out  1  one-cycle pulse, fetch complete.
REQ-007 i_rdata  out  32  fetched word, valid with i_ack, held until next i_ack.
REQ-008 d_req  in  1  data request, held high with stable fields until d_ack.
REQ-009 d_write  in  1  1 = store, 0 = load.
REQ-010 d_addr  in  32  data byte address.
REQ-011 d_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-012 d_signed  in  1  sign-extend load result.
REQ-013 d_wdata  in  32  store data, right-aligned.
REQ-014 d_ack  out  1  one-cycle pulse, data access complete.
REQ-015 d_rdata  out  32  extended load result, valid with d_ack, held until next d_ack.
REQ-016 d_err  out  1  misaligned access flag, valid only with d_ack.
REQ-017 address  out  32  bus word address.
REQ-018 read, write  out  1 each  bus strobes, never both high.
REQ-019 byteenable  out  4  active byte lanes.
REQ-020 writedata  out  32  lane-steered store data.
REQ-021 waitrequest  in  1  slave stall; transfer completes on a rising edge where read|write=1 and waitrequest=0.
REQ-022 readdata  in  32  slave data, valid in the completing cycle.

Function
REQ-023 FSM states IDLE, ACCESS, GAP, ERR; all bus outputs are registered.
REQ-024 IDLE: requests sampled only here; no request -> stay; grant -> latch fields, enter ACCESS.
REQ-025 Arbitration: single requester wins; if both request, ROUND_ROBIN=1 grants the port not served last (data after reset), ROUND_ROBIN=0 grants data.
REQ-026 Granted data access misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> enter ERR, no strobe ever asserted.
REQ-027 ERR: d_ack=1, d_err=1 for one cycle, d_rdata unchanged, then IDLE.
REQ-028 ACCESS: read or write asserted; address, byteenable, writedata and strobes held constant every cycle until completion.
REQ-029 Completion (waitrequest=0 sampled at edge): strobes drop next cycle, readdata captured and extended, enter GAP.
REQ-030 GAP: exactly one cycle, read=write=0, granted port's ack=1 (d_err=0), then IDLE; ensures strobes low for at least one cycle between transfers.
REQ-031 address = {addr[31:2],2'b00}; fetches always use byteenable 1111 and read.
REQ-032 byteenable: byte -> 0001 << addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-033 writedata: byte -> wdata[7:0] replicated x4; half -> wdata[15:0] replicated x2; word -> wdata.
REQ-034 Loads: select lane(s) by addr[1:0]; d_signed=1 sign-extends from bit 7/15, else zero-extends.
REQ-035 Latency: ack asserted 2+N cycles after grant edge, where N = ACCESS cycles with waitrequest=1; minimum 2.
REQ-036 Requests arriving during ACCESS/GAP/ERR wait; a request held high across GAP is granted in the following IDLE.

Reset
REQ-037 reset asynchronously forces state IDLE, read=write=0, i_ack=d_ack=d_err=0, address/byteenable/writedata/i_rdata/d_rdata=0, round-robin pointer to "instruction last".
REQ-038 Reset during ACCESS abandons the transfer with no ack; first post-reset grant behaves as after power-up.

Verification
REQ-039 lw 0x10, slave readdata 0xDEADBEEF, waitrequest low in first ACCESS cycle -> byteenable 1111, d_ack 2 cycles after grant, d_rdata 0xDEADBEEF.
REQ-040 lb 0x13 signed, readdata 0x80000000 -> byteenable 1000, d_rdata 0xFFFFFF80; same with d_signed=0 -> 0x00000080.
REQ-041 sh 0x22 wdata 0x1234ABCD, waitrequest high 5 cycles -> address 0x20, byteenable 1100, writedata 0xABCDABCD stable throughout, d_ack 7 cycles after grant.
REQ-042 lw 0x101 -> read/write never asserted, d_ack=d_err=1 one cycle after grant.
REQ-043 i_req and d_req both held high, ROUND_ROBIN=1 -> grants D,I,D,I; read low one GAP cycle between each.
REQ-044 reset pulsed mid-ACCESS -> read drops immediately, no ack, next lw 0x10 completes normally.
